mux_wr_dest_pipe: RTL
=====================

Name: mux_wr_dest_pipe

Overview:
- Parametrised successor to the write-register destination mux.
- Selects the register-file write destination per instruction from one of four sources: rt, SP, RA or rd.
- Carries the selected destination through a DEPTH-stage in-flight pipeline up to writeback.
- Keeps a busy scoreboard so the control unit can detect read-after-write hazards on rs/rt before issuing.

Parameters:
- ADDR_W, 5, register address width.
- NUM_REGS, 32, number of architectural registers (2**ADDR_W).
- DEPTH, 3, cycles from issue to writeback; legal range 1..8.
- SP_REG, 29, destination for seletor=01.
- RA_REG, 31, destination for seletor=10.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- seletor  input  2  destination select: 00 rt, 01 SP_REG, 10 RA_REG, 11 rd.
- rt_field  input  ADDR_W  instruction[20:16].
- rd_field  input  ADDR_W  instruction[15:11].
- issue  input  1  instruction issued this cycle.
- wr_en_in  input  1  issued instruction writes the register file.
- stall  input  1  freeze the pipeline.
- flush  input  1  kill in-flight entries not yet at writeback.
- rs_query  input  ADDR_W  source address to check.
- rt_query  input  ADDR_W  source address to check.
- dest_sel  output  ADDR_W  combinational selected destination (legacy mux output).
- wb_valid  output  1  writeback stage holds a live write.
- wb_addr  output  ADDR_W  writeback destination.
- busy_mask  output  NUM_REGS  bit i = a live in-flight write targets register i.
- hazard  output  1  busy_mask[rs_query] | busy_mask[rt_query].
- inflight_cnt  output  4  number of live entries across stages 1..DEPTH.

Behaviour:
- **Reset:** reset low clears all stage valid bits and addresses at once (asynchronous). While in reset: wb_valid=0, wb_addr=0, busy_mask=0, hazard=0, inflight_cnt=0. Reset release takes effect on the next clk edge.
- **Destination select:** dest_sel is purely combinational: 00 -> rt_field, 01 -> SP_REG, 10 -> RA_REG, 11 -> rd_field. It has no default case beyond these four.
- **Pipeline:** stages 1..DEPTH, each holding {valid, addr}.
- **Issue:** on a rising edge with stall=0 and flush=0, stage1 <= {issue & wr_en_in & (dest_sel!=0), dest_sel}.
  - A write to register 0 enters as not valid.
  - Stage k <= stage k-1 for k=2..DEPTH.
- **Latency:** an entry issued at edge N appears at stage DEPTH, i.e. on wb_valid/wb_addr, after edge N+DEPTH-1. With DEPTH=1 it appears right after the issue edge.
- **Stall:** stall=1 holds every stage and ignores issue.
  - The stage-DEPTH contents remain visible.
  - The consumer must not commit the same write twice; the register file writes only on a non-stalled cycle.
- **Flush:** flush=1 (priority over stall and issue):
  - Stage DEPTH still advances out (write completes).
  - Stages 1..DEPTH-1 receive valid=0.
  - Stage1 receives valid=0, and issue is dropped.
  - With DEPTH=1, flush only drops the issue.
- **busy_mask:** combinational OR over stages 1..DEPTH of one-hot(addr) gated by valid.
  - Bit 0 is always 0.
  - Duplicate destinations in several stages are legal; the bit stays set until the last one leaves.
- **hazard:** combinational from the current busy_mask. A query of register 0 never raises hazard.
- **inflight_cnt:** combinational popcount of the stage valid bits; maximum DEPTH.
- **Simultaneous events:** a stage leaving writeback and a new issue to the same register in the same cycle keep the bit set.

Decomposition:
- Shared package (cpu_defs):
  - Select encodings SEL_RT=2'b00, SEL_SP=2'b01, SEL_RA=2'b10, SEL_RD=2'b11.
  - Constants REG_SP=29, REG_RA=31, REG_ZERO=0.
  - Typedef for the stage entry {valid, addr}.
- Sub-module wr_dest_stage: a single {valid, addr} register with stall/kill controls, instantiated DEPTH times via generate.
- Select logic, scoreboard OR and popcount stay in the top module.

Test Plan:
- **Reset mid-flight:** issue rd=8, then drop reset low after 1 cycle -> wb_valid=0, busy_mask=0, inflight_cnt=0 immediately, without waiting for clk.
- **Select and latency (DEPTH=3):** issue seletor=11, rd=9, wr_en=1 at edge 0 -> busy_mask[9]=1 after edge 0; wb_valid=1, wb_addr=9 after edge 2; busy_mask=0 after edge 3.
- **Fixed destinations:** seletor=01 -> dest_sel=29; seletor=10 -> dest_sel=31; seletor=00, rt=5 -> dest_sel=5.
- **Zero-register suppression:** seletor=00, rt=0, wr_en=1 issued -> inflight_cnt stays 0, wb_valid never asserts.
- **Hazard:** issue rt=7 then query rs_query=7 -> hazard=1 for 3 cycles; rt_query=0 -> hazard=0.
- **Stall and flush:**
  - Issue rd=4, rd=6, rd=10 on consecutive cycles, then stall for 2 cycles -> wb_addr=4 held, inflight_cnt=3.
  - Then flush -> 4 retires; 6 and 10 are dropped; busy_mask=0 and inflight_cnt=0 after that edge.

Source files
------------

// File: rtl/mux_wr_dest_pipe_pkg.sv
// Shared CPU definitions for the write-destination pipeline.
// Select encodings, fixed register numbers and the in-flight stage entry type.
package cpu_defs;

    localparam int unsigned CPU_ADDR_W = 5;

    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_SP = 2'b01;
    localparam logic [1:0] SEL_RA = 2'b10;
    localparam logic [1:0] SEL_RD = 2'b11;

    localparam logic [CPU_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [CPU_ADDR_W-1:0] REG_RA   = 5'd31;
    localparam logic [CPU_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [CPU_ADDR_W-1:0] addr;
    } wr_entry_t;

endpackage

// File: rtl/mux_wr_dest_pipe_stage.sv
// One in-flight {valid, addr} slot of the write-destination pipeline.
// Kill has priority over hold so a flush always empties the slot.
module wr_dest_stage #(
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hold,
    input  logic              i_kill,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr
);

    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;

    // Slot register: clear, kill, hold or load from the previous stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_kill) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_hold) begin
            r_valid <= r_valid;
            r_addr  <= r_addr;
        end else begin
            r_valid <= i_valid;
            r_addr  <= i_addr;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;

endmodule

// File: rtl/mux_wr_dest_pipe.sv
// Write-destination select plus a DEPTH-stage in-flight pipeline to writeback,
// with a busy scoreboard and hazard flag for rs/rt queries. DEPTH must be 1..8.
module mux_wr_dest_pipe
    import cpu_defs::*;
#(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned SP_REG   = 29,
    parameter int unsigned RA_REG   = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          seletor,
    input  logic [ADDR_W-1:0]   rt_field,
    input  logic [ADDR_W-1:0]   rd_field,
    input  logic                issue,
    input  logic                wr_en_in,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   rs_query,
    input  logic [ADDR_W-1:0]   rt_query,
    output logic [ADDR_W-1:0]   dest_sel,
    output logic                wb_valid,
    output logic [ADDR_W-1:0]   wb_addr,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                hazard,
    output logic [3:0]          inflight_cnt
);

    logic [ADDR_W-1:0]   w_dest_sel;
    logic                w_valid [0:DEPTH];
    logic [ADDR_W-1:0]   w_addr  [0:DEPTH];
    logic [NUM_REGS-1:0] w_busy;
    logic [3:0]          w_cnt;

    // Legacy destination mux; the four encodings cover the whole select space.
    always_comb begin
        w_dest_sel = rt_field;
        case (seletor)
            SEL_RT: w_dest_sel = rt_field;
            SEL_SP: w_dest_sel = ADDR_W'(SP_REG);
            SEL_RA: w_dest_sel = ADDR_W'(RA_REG);
            SEL_RD: w_dest_sel = rd_field;
        endcase
    end

    // Writes to register 0 are discarded architecturally, so never track them.
    assign w_valid[0] = issue & wr_en_in & (w_dest_sel != ADDR_W'(REG_ZERO));
    assign w_addr[0]  = w_dest_sel;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        wr_dest_stage #(
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (reset),
            .i_hold  (stall),
            .i_kill  (flush),
            .i_valid (w_valid[k-1]),
            .i_addr  (w_addr[k-1]),
            .o_valid (w_valid[k]),
            .o_addr  (w_addr[k])
        );
    end

    // Scoreboard OR and live-entry count across every stage.
    always_comb begin
        w_busy = '0;
        w_cnt  = 4'd0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_busy[w_addr[k]] = w_busy[w_addr[k]] | w_valid[k];
            w_cnt             = w_cnt + {3'b000, w_valid[k]};
        end
        w_busy[0] = 1'b0;
    end

    assign dest_sel     = w_dest_sel;
    assign wb_valid     = w_valid[DEPTH];
    assign wb_addr      = w_addr[DEPTH];
    assign busy_mask    = w_busy;
    assign hazard       = w_busy[rs_query] | w_busy[rt_query];
    assign inflight_cnt = w_cnt;

endmodule
